rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares one external 8-bit ROM/SRAM read port between NUM_REQ requesters. Typical requesters are CPU program EPROMs 9C/9D/12C/12D and the tile gfx EPROMs 7R/7S/4R/4S.
- Sits between the subsystems' eeprom_*_addr/data buses and the single physical memory on the FPGA board.
- Arbitration is round-robin. Each fetch has a fixed, parameterised latency.
- Each requester gets a one-cycle acknowledge and a private data register that holds its value until the next fetch.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 2..8).
- ADDR_W, 20, external memory address width. Requesters present full physical addresses; bank offsets are applied upstream.
- MEM_LATENCY, 2, cycles MEM_CE is held before MEM_D is sampled (legal range 1..15).

Ports:
- CLK_48M  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NUM_REQ  per-requester level request.
- REQ_A  input  NUM_REQ*ADDR_W  packed addresses; slice i is [i*ADDR_W +: ADDR_W].
- ACK  output  NUM_REQ  one-cycle pulse; Q slice i is valid from this cycle.
- Q  output  NUM_REQ*8  packed per-requester data registers.
- MEM_A  output  ADDR_W  external address, registered.
- MEM_CE  output  1  external chip enable, active high, registered.
- MEM_D  input  8  external read data.
- BUSY  output  1  high while a fetch is in progress (state WAIT).
- GNT  output  3  index of the current or last granted requester.

Behaviour:
- Reset (RST=1 at an edge), regardless of state:
  - state=IDLE, MEM_CE=0, MEM_A=0, ACK=0, Q=0, BUSY=0, GNT=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Any fetch in flight is aborted; no ACK is issued for it.
- States: IDLE and WAIT. A 4-bit counter cnt is used in WAIT.
- IDLE:
  - eligible = REQ & ~ACK. A requester acknowledged this cycle is masked for this cycle only.
  - If eligible != 0: g = first set bit searching last+1, last+2, … with wrap modulo NUM_REQ.
  - Registered on that edge: MEM_A<=REQ_A[g], MEM_CE<=1, GNT<=g, last<=g, cnt<=MEM_LATENCY-1, BUSY<=1, state<=WAIT.
  - Otherwise remain in IDLE with MEM_CE=0.
- WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: Q[GNT]<=MEM_D, ACK[GNT]<=1 (all other ACK bits 0), MEM_CE<=0, BUSY<=0, state<=IDLE.
- ACK is high for exactly one cycle. Only one ACK bit is ever high at a time.
- Latency: REQ[i] is sampled high in IDLE at cycle 0. MEM_CE=1 in cycles 1..MEM_LATENCY. MEM_D is sampled at the end of cycle MEM_LATENCY. ACK[i] and Q valid in cycle MEM_LATENCY+1.
- Throughput: the ACK cycle is also an IDLE decision cycle, so back-to-back fetches have a period of MEM_LATENCY+1 cycles. MEM_CE is low for exactly one cycle between fetches.
- Requester rules:
  - REQ_A[i] is latched at grant. Changes after grant do not affect the fetch in flight.
  - A requester drops REQ in the cycle it sees ACK, or keeps REQ high to request again. Either way it is not re-granted in the ACK cycle.
  - A REQ that falls before grant is simply not served. No request memory is kept.
- Q slices change only on their own ACK. A slice holds its value indefinitely otherwise.
- Simultaneous requests: round robin guarantees any requester that holds REQ is served within NUM_REQ grants.
- Non-power-of-two NUM_REQ: the search wraps at NUM_REQ, not 2^k. Bits of GNT above clog2(NUM_REQ) are 0.

Test Plan:
- Single request, MEM_LATENCY=2, REQ_A[1]=0x01234 with MEM_D=0xA5 while MEM_A=0x01234 -> MEM_CE high cycles 1–2 with MEM_A=0x01234, ACK=4'b0010 in cycle 3, Q[15:8]=0xA5, BUSY low in cycle 3.
- REQ=4'b1111 from reset, held -> grant order 0,1,2,3,0…; ACK pulses in cycles 3,6,9,12; MEM_CE low exactly cycles 3,6,9.
- REQ[2] held continuously, REQ[0] raised in cycle 4 -> grants alternate 2,0,2,0. REQ[2] is never granted in its own ACK cycle.
- RST asserted in cycle 2 of a fetch -> next cycle MEM_CE=0, Q=0, ACK=0, state IDLE. After release, REQ=4'b1000 gets granted with GNT=3.
- MEM_LATENCY=1, NUM_REQ=3, REQ=3'b111 -> fetch period of 2 cycles, grant order 0,1,2,0. Search wraps at 3.
- Q retention: after requester 0 is acknowledged with 0x5A, 10 fetches by requester 1 -> Q[7:0] stays 0x5A.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: round-robin sharing of one external 8-bit read port
// between NUM_REQ requesters. Each fetch holds MEM_CE for MEM_LATENCY
// cycles, then samples MEM_D into the winner's private Q slice and pulses
// that requester's ACK for one cycle.
//
// Handshake: REQ[i] is a level request. A grant latches REQ_A[i]; the
// requester sees ACK[i] high for exactly one cycle, and Q slice i is valid
// from that cycle on until its next ACK. A requester acknowledged in a
// cycle is never re-granted in that same cycle.
//
// BUSY is a direct decode of the FSM state (high in WAIT) and doubles as
// the state observation point.
module rom_fetch_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 20,
    parameter int MEM_LATENCY = 2
) (
    input  logic                      CLK_48M,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_A,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [NUM_REQ*8-1:0]      Q,
    output logic [ADDR_W-1:0]         MEM_A,
    output logic                      MEM_CE,
    input  logic [7:0]                MEM_D,
    output logic                      BUSY,
    output logic [2:0]                GNT
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             last_q, last_d;
    logic [2:0]             gnt_q, gnt_d;
    logic [ADDR_W-1:0]      mem_a_q, mem_a_d;
    logic                   mem_ce_q, mem_ce_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ*8-1:0]   q_q, q_d;

    logic [NUM_REQ-1:0]     eligible;
    logic                   found;
    logic [2:0]             sel;

    // Round-robin search: first eligible index above last, else wrap to the
    // lowest eligible index at or below last. Wraps at NUM_REQ, not 2^k.
    always_comb begin
        eligible = REQ & ~ack_q;
        found    = 1'b0;
        sel      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (3'(i) > last_q)) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (3'(i) <= last_q)) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
    end

    // Next-state logic: grant in IDLE, count down and complete in WAIT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        mem_a_d  = mem_a_q;
        mem_ce_d = mem_ce_q;
        ack_d    = '0;
        q_d      = q_q;

        case (state_q)
            S_IDLE: begin
                mem_ce_d = 1'b0;
                if (found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel == 3'(i)) begin
                            mem_a_d = REQ_A[i*ADDR_W +: ADDR_W];
                        end
                    end
                    mem_ce_d = 1'b1;
                    gnt_d    = sel;
                    last_d   = sel;
                    cnt_d    = 4'(MEM_LATENCY - 1);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt_q == 3'(i)) begin
                            q_d[i*8 +: 8] = MEM_D;
                            ack_d[i]      = 1'b1;
                        end
                    end
                    mem_ce_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_ce_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any fetch in flight without an ACK.
    always_ff @(posedge CLK_48M) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 3'(NUM_REQ - 1);
            gnt_q    <= '0;
            mem_a_q  <= '0;
            mem_ce_q <= 1'b0;
            ack_q    <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            mem_a_q  <= mem_a_d;
            mem_ce_q <= mem_ce_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
        end
    end

    assign ACK    = ack_q;
    assign Q      = q_q;
    assign MEM_A  = mem_a_q;
    assign MEM_CE = mem_ce_q;
    assign BUSY   = (state_q == S_WAIT);
    assign GNT    = gnt_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter: a 4-requester/latency-2 instance and a
// 3-requester/latency-1 instance, both fed by a combinational ROM model.
module tb_rom_fetch_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 20;
  localparam int ML  = 2;
  localparam int NRB = 3;
  localparam int MLB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_a;
  logic [NR-1:0]    ack;
  logic [NR*8-1:0]  q;
  logic [AW-1:0]    mem_a;
  logic             mem_ce;
  logic [7:0]       mem_d;
  logic             busy;
  logic [2:0]       gnt;

  logic              rst_b;
  logic [NRB-1:0]    req_b;
  logic [NRB*AW-1:0] req_a_b;
  logic [NRB-1:0]    ack_b;
  logic [NRB*8-1:0]  q_b;
  logic [AW-1:0]     mem_a_b;
  logic              mem_ce_b;
  logic [7:0]        mem_d_b;
  logic              busy_b;
  logic [2:0]        gnt_b;

  rom_fetch_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MEM_LATENCY(ML)) dut (
    .CLK_48M(clk), .RST(rst), .REQ(req), .REQ_A(req_a), .ACK(ack), .Q(q),
    .MEM_A(mem_a), .MEM_CE(mem_ce), .MEM_D(mem_d), .BUSY(busy), .GNT(gnt)
  );

  rom_fetch_arbiter #(.NUM_REQ(NRB), .ADDR_W(AW), .MEM_LATENCY(MLB)) dut_b (
    .CLK_48M(clk), .RST(rst_b), .REQ(req_b), .REQ_A(req_a_b), .ACK(ack_b), .Q(q_b),
    .MEM_A(mem_a_b), .MEM_CE(mem_ce_b), .MEM_D(mem_d_b), .BUSY(busy_b), .GNT(gnt_b)
  );

  // ROM model: a few fixed contents, otherwise a hash of the address.
  function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
    if (a == 20'h01234) return 8'hA5;
    if (a == 20'h00ABC) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
  endfunction

  assign mem_d   = mem_fn(mem_a);
  assign mem_d_b = mem_fn(mem_a_b);

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [10:0] exp_q[$];  // {requester index, expected data}

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_fetch(input int i, input logic [AW-1:0] a);
    exp_q.push_back({3'(i), mem_fn(a)});
  endtask

  task automatic sb_compare(input string tag, input logic [7:0] ack_v,
                            input logic [2:0] gnt_v, input logic [63:0] q_v);
    logic [10:0] e;
    logic [7:0]  exp_ack;
    int          idx;
    if (exp_q.size() == 0) begin
      check({tag, "_ack_unexpected"}, 64'(ack_v), 64'(0));
      return;
    end
    e       = exp_q.pop_front();
    idx     = int'(e[10:8]);
    exp_ack = 8'(1) << idx;
    check({tag, "_ack"}, 64'(ack_v), 64'(exp_ack));
    check({tag, "_gnt"}, 64'(gnt_v), 64'(e[10:8]));
    check({tag, "_q"}, 64'(q_v[idx*8 +: 8]), 64'(e[7:0]));
  endtask

  // Wait (bounded) for an ACK on the main instance, then score it.
  task automatic wait_ack(input string tag, input int budget);
    int n;
    n = 0;
    while (ack === '0 && n < budget) begin
      tick;
      n++;
    end
    sb_compare(tag, 8'(ack), gnt, 64'(q));
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_a[i*AW +: AW] = a;
  endtask

  // Safety net: the directed sequence is bounded, this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] a0;
    logic [AW-1:0] a2;
    bit            is_ack;

    rst = 1'b1; req = '0; req_a = '0;
    rst_b = 1'b1; req_b = '0; req_a_b = '0;
    tick;
    tick;

    // Reset state
    check("rst_ce", 64'(mem_ce), 64'(0));
    check("rst_mem_a", 64'(mem_a), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_q", 64'(q), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_b_ce", 64'(mem_ce_b), 64'(0));
    check("rst_b_q", 64'(q_b), 64'(0));
    rst = 1'b0;
    rst_b = 1'b0;

    // Single request from requester 1, cycle-exact latency
    set_addr(1, 20'h01234);
    req = 4'b0010;
    expect_fetch(1, 20'h01234);
    tick;  // cycle 1
    check("t1_c1_ce", 64'(mem_ce), 64'(1));
    check("t1_c1_a", 64'(mem_a), 64'(20'h01234));
    check("t1_c1_busy", 64'(busy), 64'(1));
    check("t1_c1_gnt", 64'(gnt), 64'(1));
    check("t1_c1_ack", 64'(ack), 64'(0));
    tick;  // cycle 2
    check("t1_c2_ce", 64'(mem_ce), 64'(1));
    check("t1_c2_a", 64'(mem_a), 64'(20'h01234));
    check("t1_c2_ack", 64'(ack), 64'(0));
    tick;  // cycle 3
    check("t1_c3_ce", 64'(mem_ce), 64'(0));
    check("t1_c3_busy", 64'(busy), 64'(0));
    check("t1_c3_q1", 64'(q[15:8]), 64'(8'hA5));
    sb_compare("t1", 8'(ack), gnt, 64'(q));
    req = '0;
    tick;  // cycle 4
    check("t1_c4_ack_pulse", 64'(ack), 64'(0));
    check("t1_c4_q_hold", 64'(q[15:8]), 64'(8'hA5));

    // All four requesting from reset: order 0,1,2,3,0, ACK every 3 cycles
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom_range(0, 20'hFFFFF)));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_fetch(k % NR, req_a[(k % NR)*AW +: AW]);
    for (int c = 1; c <= 15; c++) begin
      tick;
      check($sformatf("t2_c%0d_ce", c), 64'(mem_ce), 64'((c % 3) != 0));
      if ((c % 3) == 0) sb_compare($sformatf("t2_c%0d", c), 8'(ack), gnt, 64'(q));
      else check($sformatf("t2_c%0d_ack", c), 64'(ack), 64'(0));
    end
    req = '0;

    // REQ[2] held, REQ[0] raised in cycle 4: grants alternate 2,0,2,0,2
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a0 = AW'($urandom_range(0, 20'hFFFFF));
    a2 = AW'($urandom_range(0, 20'hFFFFF));
    set_addr(0, a0);
    set_addr(2, a2);
    req = 4'b0100;
    expect_fetch(2, a2);
    expect_fetch(0, a0);
    expect_fetch(2, a2);
    expect_fetch(0, a0);
    expect_fetch(2, a2);
    for (int c = 1; c <= 16; c++) begin
      tick;
      is_ack = (c == 3) || (c == 7) || (c == 10) || (c == 13) || (c == 16);
      if (is_ack) sb_compare($sformatf("t3_c%0d", c), 8'(ack), gnt, 64'(q));
      else check($sformatf("t3_c%0d_ack", c), 64'(ack), 64'(0));
      if (c == 4) begin
        check("t3_c4_no_regrant", 64'(busy), 64'(0));
        req = 4'b0101;
      end
      if (c == 8) check("t3_c8_gnt", 64'(gnt), 64'(2));
      if (c == 11) check("t3_c11_gnt", 64'(gnt), 64'(0));
    end
    req = '0;
    tick;

    // Reset in cycle 2 of a fetch: aborted, Q cleared, then requester 3 wins
    set_addr(0, AW'($urandom_range(0, 20'hFFFFF)));
    req = 4'b0001;
    tick;  // cycle 1
    check("t4_c1_ce", 64'(mem_ce), 64'(1));
    tick;  // cycle 2
    rst = 1'b1;
    tick;  // cycle 3
    check("t4_c3_ce", 64'(mem_ce), 64'(0));
    check("t4_c3_q", 64'(q), 64'(0));
    check("t4_c3_ack", 64'(ack), 64'(0));
    check("t4_c3_busy", 64'(busy), 64'(0));
    check("t4_c3_gnt", 64'(gnt), 64'(0));
    rst = 1'b0;
    req = 4'b1000;
    a = AW'($urandom_range(0, 20'hFFFFF));
    set_addr(3, a);
    expect_fetch(3, a);
    tick;  // cycle 4
    check("t4_c4_ce", 64'(mem_ce), 64'(1));
    check("t4_c4_gnt", 64'(gnt), 64'(3));
    check("t4_c4_a", 64'(mem_a), 64'(a));
    check("t4_c4_ack", 64'(ack), 64'(0));
    tick;  // cycle 5
    check("t4_c5_ack", 64'(ack), 64'(0));
    tick;  // cycle 6
    sb_compare("t4_c6", 8'(ack), gnt, 64'(q));
    req = '0;
    tick;

    // Q retention: requester 0 gets 0x5A, then 10 fetches by requester 1
    set_addr(0, 20'h00ABC);
    req = 4'b0001;
    expect_fetch(0, 20'h00ABC);
    wait_ack("t6_r0", 10);
    for (int k = 0; k < 10; k++) begin
      a = AW'($urandom_range(0, 20'hFFFFF));
      set_addr(1, a);
      expect_fetch(1, a);
      req = 4'b0010;
      tick;
      tick;
      check($sformatf("t6_k%0d_mem_a", k), 64'(mem_a), 64'(a));
      set_addr(1, ~a);  // must not disturb the fetch in flight
      wait_ack($sformatf("t6_k%0d", k), 8);
      check($sformatf("t6_k%0d_q0", k), 64'(q[7:0]), 64'(8'h5A));
    end
    req = '0;
    tick;

    // NUM_REQ=3, MEM_LATENCY=1: period 2, order 0,1,2,0 wrapping at 3
    for (int i = 0; i < NRB; i++) req_a_b[i*AW +: AW] = AW'($urandom_range(0, 20'hFFFFF));
    req_b = 3'b111;
    for (int k = 0; k < 4; k++) expect_fetch(k % NRB, req_a_b[(k % NRB)*AW +: AW]);
    for (int c = 1; c <= 8; c++) begin
      tick;
      check($sformatf("t5_c%0d_ce", c), 64'(mem_ce_b), 64'((c % 2) == 1));
      if ((c % 2) == 0) sb_compare($sformatf("t5_c%0d", c), 8'(ack_b), gnt_b, 64'(q_b));
      else check($sformatf("t5_c%0d_ack", c), 64'(ack_b), 64'(0));
    end
    req_b = '0;
    tick;

    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
